// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a sequential bulk-clear engine.
// Optional same-cycle write-through to the read ports under `define REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRP      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    output logic                wr_ready,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd_data_in,
    input  logic [NRP*AW-1:0]   rs_addr,
    output logic [NRP*XLEN-1:0] rs_data,
    input  logic                clr_req,
    output logic                busy,
    output logic                clr_done
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] mem [NREGS];
    logic            wr_ok;

    // An address is backed by storage unless it is out of range or the hardwired x0.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok = we && wr_ready && addr_ok(rd_addr);

    // Clear sequencer; wr_ready is kept as its own flop tracking ~busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        wr_ready <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        wr_ready <= 1'b1;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage: scrub one entry per cycle while clearing, otherwise accept writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < NREGS; j++) begin
                mem[j] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[rd_addr] <= rd_data_in;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rs_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign rs_data[i*XLEN +: XLEN] = (wr_ok && (rd_addr == a)) ? rd_data_in
                                       : (addr_ok(a) ? mem[a] : '0);
`else
        assign rs_data[i*XLEN +: XLEN] = addr_ok(a) ? mem[a] : '0;
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three instances cover x0 handling, sizing and clear timing.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // u0: 32 regs, 2 ports, hardwired x0
    logic        we0 = 0, rdy0, clr0 = 0, busy0, done0;
    logic [4:0]  wa0 = 0;
    logic [31:0] wd0 = 0;
    logic [9:0]  rs0 = 0;
    logic [63:0] rsd0;
    // u1: 32 regs, 2 ports, ordinary x0
    logic        we1 = 0, rdy1, clr1 = 0, busy1, done1;
    logic [4:0]  wa1 = 0;
    logic [31:0] wd1 = 0;
    logic [9:0]  rs1 = 0;
    logic [63:0] rsd1;
    // u2: 24 regs, 3 ports
    logic        we2 = 0, rdy2, clr2 = 0, busy2, done2;
    logic [4:0]  wa2 = 0;
    logic [31:0] wd2 = 0;
    logic [14:0] rs2 = 0;
    logic [95:0] rsd2;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRP(2), .ZERO_REG(1)) u0 (
        .clk(clk), .rst_n(rst_n), .we(we0), .wr_ready(rdy0), .rd_addr(wa0), .rd_data_in(wd0),
        .rs_addr(rs0), .rs_data(rsd0), .clr_req(clr0), .busy(busy0), .clr_done(done0));
    regfile_mp #(.XLEN(32), .NREGS(32), .NRP(2), .ZERO_REG(0)) u1 (
        .clk(clk), .rst_n(rst_n), .we(we1), .wr_ready(rdy1), .rd_addr(wa1), .rd_data_in(wd1),
        .rs_addr(rs1), .rs_data(rsd1), .clr_req(clr1), .busy(busy1), .clr_done(done1));
    regfile_mp #(.XLEN(32), .NREGS(24), .NRP(3), .ZERO_REG(1)) u2 (
        .clk(clk), .rst_n(rst_n), .we(we2), .wr_ready(rdy2), .rd_addr(wa2), .rd_data_in(wd2),
        .rs_addr(rs2), .rs_data(rsd2), .clr_req(clr2), .busy(busy2), .clr_done(done2));

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        we0 = 1; wa0 = a; wd0 = d;
        @(posedge clk); #1;
        we0 = 0;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d);
        we1 = 1; wa1 = a; wd1 = d;
        @(posedge clk); #1;
        we1 = 0;
    endtask

    task automatic wr2(input logic [4:0] a, input logic [31:0] d);
        we2 = 1; wa2 = a; wd2 = d;
        @(posedge clk); #1;
        we2 = 0;
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        rs0 = {5'd5, 5'd5};
        #1;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", rdy0); end
        checks++; if ({busy1, done1, rdy1} !== 3'b001) begin errors++; $display("FAIL reset_u1_flags: got %b expected 001", {busy1, done1, rdy1}); end
        checks++; if ({busy2, done2, rdy2} !== 3'b001) begin errors++; $display("FAIL reset_u2_flags: got %b expected 001", {busy2, done2, rdy2}); end
        exp_q.push_back(32'h0);
        checks++; exp = exp_q.pop_front();
        if (rsd0[31:0] !== exp) begin errors++; $display("FAIL reset_read: got %h expected %h", rsd0[31:0], exp); end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_write_read();
        wr0(5'd5, 32'hDEADBEEF);
        rs0 = {5'd5, 5'd5};
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
        #1;
        checks++; exp = exp_q.pop_front();
        if (rsd0[31:0] !== exp) begin errors++; $display("FAIL wr_rd_p0: got %h expected %h", rsd0[31:0], exp); end
        checks++; exp = exp_q.pop_front();
        if (rsd0[63:32] !== exp) begin errors++; $display("FAIL wr_rd_p1: got %h expected %h", rsd0[63:32], exp); end
        wr0(5'd31, 32'h0F0F0F0F);
        rs0 = {5'd31, 5'd5};
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0F0F0F0F);
        #1;
        checks++; exp = exp_q.pop_front();
        if (rsd0[31:0] !== exp) begin errors++; $display("FAIL wr_rd_mixed_p0: got %h expected %h", rsd0[31:0], exp); end
        checks++; exp = exp_q.pop_front();
        if (rsd0[63:32] !== exp) begin errors++; $display("FAIL wr_rd_mixed_p1: got %h expected %h", rsd0[63:32], exp); end
    endtask

    task automatic test_zero_reg();
        wr0(5'd0, 32'h12345678);
        wr1(5'd0, 32'h12345678);
        rs0 = {5'd0, 5'd0};
        rs1 = {5'd0, 5'd0};
        exp_q.push_back(32'h0); exp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678);
        #1;
        checks++; exp = exp_q.pop_front();
        if (rsd0[31:0] !== exp) begin errors++; $display("FAIL x0_hardwired: got %h expected %h", rsd0[31:0], exp); end
        checks++; exp = exp_q.pop_front();
        if (rsd1[31:0] !== exp) begin errors++; $display("FAIL x0_ordinary_p0: got %h expected %h", rsd1[31:0], exp); end
        checks++; exp = exp_q.pop_front();
        if (rsd1[63:32] !== exp) begin errors++; $display("FAIL x0_ordinary_p1: got %h expected %h", rsd1[63:32], exp); end
    endtask

    task automatic test_bypass();
        wr0(5'd7, 32'h11111111);
        rs0 = {5'd7, 5'd7};
        we0 = 1; wa0 = 5'd7; wd0 = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'hA5A5A5A5);
`else
        exp_q.push_back(32'h11111111);
`endif
        exp_q.push_back(32'hA5A5A5A5);
        #1;
        checks++; exp = exp_q.pop_front();
        if (rsd0[63:32] !== exp) begin errors++; $display("FAIL bypass_same_cycle: got %h expected %h", rsd0[63:32], exp); end
        @(posedge clk); #1;
        we0 = 0;
        #1;
        checks++; exp = exp_q.pop_front();
        if (rsd0[31:0] !== exp) begin errors++; $display("FAIL bypass_next_cycle: got %h expected %h", rsd0[31:0], exp); end
        rs0 = {5'd0, 5'd0};
        we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        exp_q.push_back(32'h0);
        #1;
        checks++; exp = exp_q.pop_front();
        if (rsd0[31:0] !== exp) begin errors++; $display("FAIL bypass_x0_dropped: got %h expected %h", rsd0[31:0], exp); end
        @(posedge clk); #1;
        we0 = 0;
    endtask

    task automatic test_bulk_clear();
        int busy_cycles;
        for (int i = 1; i < 32; i++) wr0(5'(i), 32'(i));
        clr0 = 1;
        @(posedge clk); #1;
        clr0 = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 100; k++) begin
            we0 = 0;
            if (!busy0) begin
                checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL clr_done_pulse: got %b expected 1", done0); end
                break;
            end
            busy_cycles++;
            if (k == 5) begin
                we0 = 1; wa0 = 5'd3; wd0 = 32'h33333333;
                rs0 = {5'd20, 5'd3};
                exp_q.push_back(32'h0); exp_q.push_back(32'd20);
                #1;
                checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL clr_wr_ready: got %b expected 0", rdy0); end
                checks++; exp = exp_q.pop_front();
                if (rsd0[31:0] !== exp) begin errors++; $display("FAIL clr_live_x3: got %h expected %h", rsd0[31:0], exp); end
                checks++; exp = exp_q.pop_front();
                if (rsd0[63:32] !== exp) begin errors++; $display("FAIL clr_live_x20: got %h expected %h", rsd0[63:32], exp); end
            end
            if (k == 10) begin
                rs0 = {5'd9, 5'd8};
                exp_q.push_back(32'h0); exp_q.push_back(32'd9);
                #1;
                checks++; exp = exp_q.pop_front();
                if (rsd0[31:0] !== exp) begin errors++; $display("FAIL clr_live_x8: got %h expected %h", rsd0[31:0], exp); end
                checks++; exp = exp_q.pop_front();
                if (rsd0[63:32] !== exp) begin errors++; $display("FAIL clr_live_x9: got %h expected %h", rsd0[63:32], exp); end
            end
            @(posedge clk); #1;
        end
        checks++; if (busy_cycles != 32) begin errors++; $display("FAIL clr_busy_cycles: got %0d expected 32", busy_cycles); end
        @(posedge clk); #1;
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL clr_done_width: got %b expected 0", done0); end
        for (int r = 0; r < 32; r++) begin
            rs0 = {5'(r), 5'(r)};
            exp_q.push_back(32'h0);
            #1;
            checks++; exp = exp_q.pop_front();
            if (rsd0[63:32] !== exp) begin errors++; $display("FAIL clr_result x%0d: got %h expected %h", r, rsd0[63:32], exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sizing();
        int busy_cycles;
        wr2(5'd23, 32'h23232323);
        wr2(5'd30, 32'hBADBAD00);
        rs2 = {5'd23, 5'd30, 5'd23};
        exp_q.push_back(32'h23232323); exp_q.push_back(32'h0); exp_q.push_back(32'h23232323);
        #1;
        checks++; exp = exp_q.pop_front();
        if (rsd2[31:0] !== exp) begin errors++; $display("FAIL size_p0_x23: got %h expected %h", rsd2[31:0], exp); end
        checks++; exp = exp_q.pop_front();
        if (rsd2[63:32] !== exp) begin errors++; $display("FAIL size_p1_x30: got %h expected %h", rsd2[63:32], exp); end
        checks++; exp = exp_q.pop_front();
        if (rsd2[95:64] !== exp) begin errors++; $display("FAIL size_p2_x23: got %h expected %h", rsd2[95:64], exp); end
        clr2 = 1;
        @(posedge clk); #1;
        busy_cycles = 0;
        for (int k = 0; k < 100 && busy2; k++) begin
            busy_cycles++;
            @(posedge clk); #1;
        end
        checks++; if (busy_cycles != 24) begin errors++; $display("FAIL size_clear_cycles: got %0d expected 24", busy_cycles); end
        checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL size_done: got %b expected 1", done2); end
        @(posedge clk); #1;
        checks++; if ({busy2, done2} !== 2'b00) begin errors++; $display("FAIL size_idle_gap: got %b expected 00", {busy2, done2}); end
        @(posedge clk); #1;
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL size_restart: got %b expected 1", busy2); end
        clr2 = 0;
        for (int k = 0; k < 100 && busy2; k++) begin
            @(posedge clk); #1;
        end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL size_second_clear_timeout: busy got %b expected 0", busy2); end
        exp_q.push_back(32'h0);
        #1;
        checks++; exp = exp_q.pop_front();
        if (rsd2[31:0] !== exp) begin errors++; $display("FAIL size_cleared_x23: got %h expected %h", rsd2[31:0], exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_clear();
        int pulses;
        wr0(5'd20, 32'h0000CAFE);
        wr0(5'd31, 32'h0000BEEF);
        rs0 = {5'd31, 5'd20};
        clr0 = 1;
        @(posedge clk); #1;
        clr0 = 0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        checks++; if ({busy0, rdy0, done0} !== 3'b010) begin errors++; $display("FAIL rst_mid_flags: got %b expected 010", {busy0, rdy0, done0}); end
        checks++; exp = exp_q.pop_front();
        if (rsd0[31:0] !== exp) begin errors++; $display("FAIL rst_mid_x20: got %h expected %h", rsd0[31:0], exp); end
        checks++; exp = exp_q.pop_front();
        if (rsd0[63:32] !== exp) begin errors++; $display("FAIL rst_mid_x31: got %h expected %h", rsd0[63:32], exp); end
        @(posedge clk); #1;
        rst_n = 1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done0 || busy0) pulses++;
            @(posedge clk); #1;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_bulk_clear();
        test_sizing();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
